// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone B4 slave memory with a fixed accept-to-response latency and an
// optional periodic one-cycle stall, used to exercise a master's stall and ack paths.
module wb_mem_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned STALL_EVERY = 0
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    wb_stall_o
);

    localparam int unsigned SelWidth = DATA_WIDTH / 8;
    localparam int unsigned IdxWidth = ADDR_WIDTH - 2;
    localparam int unsigned MemAw    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CntWidth = (STALL_EVERY > 1) ? $clog2(STALL_EVERY + 1) : 1;

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    logic [IdxWidth-1:0]   idx;
    logic [MemAw-1:0]      waddr;
    logic                  in_range;
    logic                  accept;
    logic [DATA_WIDTH-1:0] rd_word;

    // Delay line: stage 0 is loaded at the accept edge, the last stage drives the bus.
    logic [LATENCY-1:0]                 vld_q, vld_d;
    logic [LATENCY-1:0]                 err_q, err_d;
    logic [LATENCY-1:0][DATA_WIDTH-1:0] dat_q, dat_d;

    logic                stall_q, stall_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    // Byte offset within a word carries no meaning for a word-wide slave.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^wb_adr_i[1:0];

    assign idx      = wb_adr_i[ADDR_WIDTH-1:2];
    assign waddr    = idx[MemAw-1:0];
    // MEM_WORDS is a power of two, so in range means no index bits above the word address.
    assign in_range = ((idx >> MemAw) == '0);
    assign accept   = wb_cyc_i & wb_stb_i & ~stall_q;
    assign rd_word  = mem_q[waddr];

    // Storage: byte-lane writes at the accept edge; never cleared, never written in reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i && accept && in_range && wb_we_i) begin
            for (int b = 0; b < SelWidth; b++) begin
                if (wb_sel_i[b]) begin
                    mem_q[waddr][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
                end
            end
        end
    end

    // Delay line next state: shift by one, load the newly accepted beat, flush when cyc drops.
    always_comb begin
        vld_d = vld_q;
        err_d = err_q;
        dat_d = dat_q;
        for (int i = LATENCY - 1; i > 0; i--) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        vld_d[0] = accept;
        err_d[0] = accept & ~in_range;
        dat_d[0] = (accept && in_range && !wb_we_i) ? rd_word : '0;
        if (!wb_cyc_i) begin
            vld_d = '0;
        end
    end

    // Stall generator next state: one stall cycle after every STALL_EVERY accepts.
    always_comb begin
        cnt_d   = cnt_q;
        stall_d = 1'b0;
        if (!wb_cyc_i) begin
            cnt_d = '0;
        end else if (accept && (STALL_EVERY != 0)) begin
            if (cnt_q == CntWidth'(STALL_EVERY - 1)) begin
                cnt_d   = '0;
                stall_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset; pending responses are dropped.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            vld_q   <= '0;
            err_q   <= '0;
            dat_q   <= '0;
            stall_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            vld_q   <= vld_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            stall_q <= stall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_ack_o   = vld_q[LATENCY-1] & ~err_q[LATENCY-1];
    assign wb_err_o   = vld_q[LATENCY-1] & err_q[LATENCY-1];
    assign wb_dat_o   = wb_ack_o ? dat_q[LATENCY-1] : '0;
    assign wb_stall_o = stall_q;

endmodule
